retire_stream_checker: RTL and testbench
========================================

# retire_stream_checker

Parametrised, synthesizable checker that sits beside the core on the retire interface and watches every retired instruction. It checks fetch-address alignment against the core's misalignment flag, one-hot decode against the illegal flag, and PC sequencing across retires. It generalises the static per-cycle assertions to IALIGN 16/32, arbitrary decode width and XLEN, and adds sticky error state, counters and first-error capture usable in simulation, formal and silicon debug.

## Interface
- XLEN, 32, datapath/PC width
- IALIGN, 32, instruction alignment in bits; legal values 16 (C extension) or 32
- NUM_OPS, 37, width of the decode vector checked for one-hot
- CNT_W, 8, error counter width
- clk  in  1  clock; all state updates on the rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- ret_valid  in  1  one instruction retires this cycle
- ret_pc  in  XLEN  PC of the retiring instruction
- ret_compressed  in  1  retiring instruction is 16-bit; ignored when IALIGN=32
- ret_redirect  in  1  instruction changed control flow (taken branch, jump, trap, mret)
- ret_target  in  XLEN  next PC when ret_redirect=1
- ret_misaligned  in  1  core raised instruction-address-misaligned for this retire
- ret_decode  in  NUM_OPS  decode vector
- ret_illegal  in  1  core flagged the instruction illegal
- clear  in  1  clear sticky flags, counter and capture
- err_misalign / err_onehot / err_pc_seq  out  1 each  sticky error flags
- err_pulse  out  1  one-cycle pulse: the previous cycle's retire had at least one error
- err_count  out  CNT_W  saturating count of erroneous retires
- first_err_pc  out  XLEN  ret_pc of the first erroneous retire since reset/clear
- first_err_code  out  2  0 none, 1 misalign, 2 onehot, 3 pc_seq

## Operation
- All inputs are ignored when ret_valid=0; state holds.
- Misalign check: error when (ret_pc mod IALIGN/8 ≠ 0) XOR ret_misaligned. The flag must be raised exactly when misaligned.
- One-hot check: error when ret_illegal=0 and ret_decode is not exactly one-hot. ret_illegal=1 waives the check.
- PC sequence FSM, states SYNC and TRACK; reset state is SYNC.
  - SYNC: no expected PC and no sequence check. A valid retire seeds exp_pc and moves to TRACK.
  - TRACK: error when ret_pc ≠ exp_pc.
  - Next exp_pc: ret_target if ret_redirect; else ret_pc+2 if IALIGN=16 and ret_compressed; else ret_pc+4. All arithmetic is mod 2^XLEN, so wrap at all-ones is legal.
  - A retire with ret_misaligned=1 and ret_redirect=0 returns the FSM to SYNC, because the trap target is unknown.
- Per-retire error classification:
  - Several checks can fail on one retire. All corresponding flags are set, err_count increments by 1 only, and the code takes priority misalign > onehot > pc_seq.
  - err_count saturates at 2^CNT_W−1.
  - first_err_pc/code are captured only when no error has been recorded since reset or clear.
- clear and an erroneous retire in the same cycle: the error wins. Flags show only the new error, err_count=1, and the capture holds the new error. clear does not affect the FSM.

## Timing
- All outputs are registered, with 1-cycle latency from the sampled retire to the flags, err_pulse, count and capture.
- Back-to-back retires are accepted every cycle with no stalls. The checker has no backpressure.
- Reset values: all flags 0, err_pulse 0, err_count 0, first_err_pc 0, first_err_code 0, FSM SYNC, exp_pc 0.
- Reset asserted mid-stream: the next retire after reset is treated as a SYNC seed.

## Configuration
- RETIRE_CHECK_ASSERT_EN:
  - Defined: the block also embeds concurrent assertions, one per check, disabled during cpu_rst, plus an elaboration-time check that IALIGN is 16 or 32. These are for formal and simulation.
  - Undefined: only flags and counters exist, and the RTL is fully synthesizable with no assertion constructs.

## Structure
- Shared package holds:
  - the error-code enum (NONE, MISALIGN, ONEHOT, PC_SEQ)
  - the FSM state enum
  - the instruction step constants (2 and 4)
- One sub-module, retire_err_recorder: sticky flags, saturating counter, first-error capture and clear handling. The top module holds the checks and the FSM.

## Test plan
- Reset, then retires at 0x100 then 0x104, both 32-bit, no redirect → no errors, err_count=0.
- IALIGN=32, retire pc=0x102 with ret_misaligned=0 → next cycle err_misalign=1, err_pulse=1, first_err_code=1, first_err_pc=0x102.
- ret_decode=0b0110, ret_illegal=0 → err_onehot=1, and err_count increments from 0 to 1. The same vector with ret_illegal=1 gives no error.
- IALIGN=16:
  - compressed retire at 0x200 then a retire at 0x202 → clean.
  - next retire at 0x210 with no redirect (expected 0x206) → err_pc_seq=1, code=3.
- CNT_W=2, five erroneous retires → err_count stays 3. Then clear together with an erroneous onehot retire → err_count=1, code=2, err_misalign=0.
- Retire at 0xFFFF_FFFC, non-redirect, then a retire at 0x0 → no pc_seq error (wrap). Assert cpu_rst mid-stream, then retire at 0x500 → no pc_seq error (SYNC seed).

Source files
------------

// File: rtl/retire_stream_checker_pkg.sv
// Shared types and constants for the retire-stream checker.
package retire_stream_checker_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_ONEHOT   = 2'd2,
        ERR_PC_SEQ   = 2'd3
    } err_code_e;

    typedef enum logic {
        SEQ_SYNC  = 1'b0,
        SEQ_TRACK = 1'b1
    } seq_state_e;

    localparam int STEP_HALF = 2;
    localparam int STEP_WORD = 4;

endpackage

// File: rtl/retire_stream_checker_recorder.sv
// retire_err_recorder: sticky error flags, saturating error counter,
// first-error capture and clear handling for the retire checker.
module retire_err_recorder
    import retire_stream_checker_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             cpu_rst,
    input  logic             clear,
    input  logic             bad_misalign,
    input  logic             bad_onehot,
    input  logic             bad_pc_seq,
    input  logic [XLEN-1:0]  pc,
    output logic             err_misalign,
    output logic             err_onehot,
    output logic             err_pc_seq,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [XLEN-1:0]  first_err_pc,
    output logic [1:0]       first_err_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic      any_err;
    err_code_e code;
    err_code_e first_code_q;

    assign any_err = bad_misalign | bad_onehot | bad_pc_seq;

    always_comb begin
        code = ERR_NONE;
        if (bad_misalign)    code = ERR_MISALIGN;
        else if (bad_onehot) code = ERR_ONEHOT;
        else if (bad_pc_seq) code = ERR_PC_SEQ;
    end

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            err_misalign <= 1'b0;
            err_onehot   <= 1'b0;
            err_pc_seq   <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            first_err_pc <= '0;
            first_code_q <= ERR_NONE;
        end else begin
            err_pulse <= any_err;
            // A same-cycle error beats clear: restart the record from this retire.
            if (any_err && clear) begin
                err_misalign <= bad_misalign;
                err_onehot   <= bad_onehot;
                err_pc_seq   <= bad_pc_seq;
                err_count    <= CNT_W'(1);
                first_err_pc <= pc;
                first_code_q <= code;
            end else if (any_err) begin
                err_misalign <= err_misalign | bad_misalign;
                err_onehot   <= err_onehot | bad_onehot;
                err_pc_seq   <= err_pc_seq | bad_pc_seq;
                if (err_count != CNT_MAX)
                    err_count <= err_count + CNT_W'(1);
                if (first_code_q == ERR_NONE) begin
                    first_err_pc <= pc;
                    first_code_q <= code;
                end
            end else if (clear) begin
                err_misalign <= 1'b0;
                err_onehot   <= 1'b0;
                err_pc_seq   <= 1'b0;
                err_count    <= '0;
                first_err_pc <= '0;
                first_code_q <= ERR_NONE;
            end
        end
    end

    assign first_err_code = first_code_q;

endmodule

// File: rtl/retire_stream_checker.sv
// Retire-interface checker: alignment, one-hot decode and PC sequencing.
// Define RETIRE_CHECK_ASSERT_EN to embed concurrent assertions for each check.
module retire_stream_checker
    import retire_stream_checker_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IALIGN  = 32,
    parameter int NUM_OPS = 37,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               cpu_rst,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    input  logic               ret_compressed,
    input  logic               ret_redirect,
    input  logic [XLEN-1:0]    ret_target,
    input  logic               ret_misaligned,
    input  logic [NUM_OPS-1:0] ret_decode,
    input  logic               ret_illegal,
    input  logic               clear,
    output logic               err_misalign,
    output logic               err_onehot,
    output logic               err_pc_seq,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   err_count,
    output logic [XLEN-1:0]    first_err_pc,
    output logic [1:0]         first_err_code
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] exp_pc_q, exp_pc_d;
    logic [XLEN-1:0] next_pc;
    logic            addr_unaligned;
    logic            decode_onehot;
    logic            bad_misalign, bad_onehot, bad_pc_seq;

    assign addr_unaligned = (IALIGN == 16) ? ret_pc[0] : (ret_pc[1:0] != 2'b00);
    assign decode_onehot  = (ret_decode != '0) &&
                            ((ret_decode & (ret_decode - NUM_OPS'(1))) == '0);

    assign bad_misalign = ret_valid && (addr_unaligned ^ ret_misaligned);
    assign bad_onehot   = ret_valid && !ret_illegal && !decode_onehot;
    assign bad_pc_seq   = ret_valid && (state_q == SEQ_TRACK) && (ret_pc != exp_pc_q);

    always_comb begin
        next_pc = ret_pc + XLEN'(STEP_WORD);
        if (ret_redirect)
            next_pc = ret_target;
        else if (IALIGN == 16 && ret_compressed)
            next_pc = ret_pc + XLEN'(STEP_HALF);
    end

    always_comb begin
        state_d  = state_q;
        exp_pc_d = exp_pc_q;
        if (ret_valid) begin
            exp_pc_d = next_pc;
            // A misaligned fault traps to an unknown handler, so drop tracking.
            state_d  = (ret_misaligned && !ret_redirect) ? SEQ_SYNC : SEQ_TRACK;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state_q  <= SEQ_SYNC;
            exp_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            exp_pc_q <= exp_pc_d;
        end
    end

    retire_err_recorder #(.XLEN(XLEN), .CNT_W(CNT_W)) u_recorder (
        .clk            (clk),
        .cpu_rst        (cpu_rst),
        .clear          (clear),
        .bad_misalign   (bad_misalign),
        .bad_onehot     (bad_onehot),
        .bad_pc_seq     (bad_pc_seq),
        .pc             (ret_pc),
        .err_misalign   (err_misalign),
        .err_onehot     (err_onehot),
        .err_pc_seq     (err_pc_seq),
        .err_pulse      (err_pulse),
        .err_count      (err_count),
        .first_err_pc   (first_err_pc),
        .first_err_code (first_err_code)
    );

`ifdef RETIRE_CHECK_ASSERT_EN
    if (IALIGN != 16 && IALIGN != 32) begin : g_ialign_chk
        $error("retire_stream_checker: IALIGN must be 16 or 32");
    end

    a_misalign: assert property (@(posedge clk) disable iff (cpu_rst) !bad_misalign);
    a_onehot:   assert property (@(posedge clk) disable iff (cpu_rst) !bad_onehot);
    a_pc_seq:   assert property (@(posedge clk) disable iff (cpu_rst) !bad_pc_seq);
`endif

endmodule

// File: tb/tb_retire_stream_checker.sv
// Bench for retire_stream_checker: IALIGN=32/CNT_W=8 and IALIGN=16/CNT_W=2
// instances share one stimulus stream and are each compared to a reference model.
module tb_retire_stream_checker;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic        ret_compressed = 1'b0;
    logic        ret_redirect = 1'b0;
    logic [31:0] ret_target = '0;
    logic        ret_misaligned = 1'b0;
    logic [36:0] ret_decode = 37'd1;
    logic        ret_illegal = 1'b0;
    logic        clear = 1'b0;

    logic        o_mis [2];
    logic        o_oh  [2];
    logic        o_seq [2];
    logic        o_pulse [2];
    logic [7:0]  o_cnt0;
    logic [1:0]  o_cnt1;
    logic [31:0] o_fpc [2];
    logic [1:0]  o_fcode [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_stream_checker #(.XLEN(32), .IALIGN(32), .NUM_OPS(37), .CNT_W(8)) dut32 (
        .clk(clk), .cpu_rst(cpu_rst), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_compressed(ret_compressed), .ret_redirect(ret_redirect), .ret_target(ret_target),
        .ret_misaligned(ret_misaligned), .ret_decode(ret_decode), .ret_illegal(ret_illegal),
        .clear(clear), .err_misalign(o_mis[0]), .err_onehot(o_oh[0]), .err_pc_seq(o_seq[0]),
        .err_pulse(o_pulse[0]), .err_count(o_cnt0), .first_err_pc(o_fpc[0]),
        .first_err_code(o_fcode[0])
    );

    retire_stream_checker #(.XLEN(32), .IALIGN(16), .NUM_OPS(37), .CNT_W(2)) dut16 (
        .clk(clk), .cpu_rst(cpu_rst), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_compressed(ret_compressed), .ret_redirect(ret_redirect), .ret_target(ret_target),
        .ret_misaligned(ret_misaligned), .ret_decode(ret_decode), .ret_illegal(ret_illegal),
        .clear(clear), .err_misalign(o_mis[1]), .err_onehot(o_oh[1]), .err_pc_seq(o_seq[1]),
        .err_pulse(o_pulse[1]), .err_count(o_cnt1), .first_err_pc(o_fpc[1]),
        .first_err_code(o_fcode[1])
    );

    // Reference model, one slot per instance.
    int          ial  [2] = '{32, 16};
    int          cmax [2] = '{255, 3};
    bit          m_track [2];
    logic [31:0] m_exp [2];
    bit          m_fm [2], m_fo [2], m_fs [2], m_pulse [2];
    int          m_cnt [2];
    logic [31:0] m_fpc [2];
    int          m_fcode [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit em, eo, es;
            int code;
            if (cpu_rst) begin
                m_track[k] = 0; m_exp[k] = '0;
                m_fm[k] = 0; m_fo[k] = 0; m_fs[k] = 0; m_pulse[k] = 0;
                m_cnt[k] = 0; m_fpc[k] = '0; m_fcode[k] = 0;
            end else begin
                em = ret_valid && (((ret_pc % (ial[k] / 8)) != 0) != ret_misaligned);
                eo = ret_valid && !ret_illegal && ($countones(ret_decode) != 1);
                es = ret_valid && m_track[k] && (ret_pc != m_exp[k]);
                code = em ? 1 : eo ? 2 : es ? 3 : 0;
                m_pulse[k] = (code != 0);
                if (code != 0) begin
                    if (clear) begin
                        m_fm[k] = em; m_fo[k] = eo; m_fs[k] = es;
                        m_cnt[k] = 1; m_fpc[k] = ret_pc; m_fcode[k] = code;
                    end else begin
                        m_fm[k] |= em; m_fo[k] |= eo; m_fs[k] |= es;
                        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                        if (m_fcode[k] == 0) begin
                            m_fpc[k] = ret_pc; m_fcode[k] = code;
                        end
                    end
                end else if (clear) begin
                    m_fm[k] = 0; m_fo[k] = 0; m_fs[k] = 0;
                    m_cnt[k] = 0; m_fpc[k] = '0; m_fcode[k] = 0;
                end
                if (ret_valid) begin
                    m_exp[k] = ret_redirect ? ret_target
                             : ret_pc + ((ial[k] == 16 && ret_compressed) ? 2 : 4);
                    m_track[k] = !(ret_misaligned && !ret_redirect);
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("err_misalign[%0d]", k), 64'(o_mis[k]), 64'(m_fm[k]));
            chk($sformatf("err_onehot[%0d]", k), 64'(o_oh[k]), 64'(m_fo[k]));
            chk($sformatf("err_pc_seq[%0d]", k), 64'(o_seq[k]), 64'(m_fs[k]));
            chk($sformatf("err_pulse[%0d]", k), 64'(o_pulse[k]), 64'(m_pulse[k]));
            chk($sformatf("err_count[%0d]", k), (k == 0) ? 64'(o_cnt0) : 64'(o_cnt1), 64'(m_cnt[k]));
            chk($sformatf("first_err_pc[%0d]", k), 64'(o_fpc[k]), 64'(m_fpc[k]));
            chk($sformatf("first_err_code[%0d]", k), 64'(o_fcode[k]), 64'(m_fcode[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        cpu_rst = 1'b1; ret_valid = 1'b0; clear = 1'b0;
        repeat (n) cycle();
        cpu_rst = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic comp = 1'b0, input logic redir = 1'b0,
                          input logic [31:0] tgt = '0, input logic mis = 1'b0,
                          input logic [36:0] dec = 37'd1, input logic ill = 1'b0);
        ret_valid = 1'b1; ret_pc = pc; ret_compressed = comp; ret_redirect = redir;
        ret_target = tgt; ret_misaligned = mis; ret_decode = dec; ret_illegal = ill;
        cycle();
        ret_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] seq_pc;
        logic [36:0] bad_dec;
        bad_dec = 37'b0110;

        do_reset(2);
        chk("rst_count32", 64'(o_cnt0), 64'd0);
        chk("rst_code16", 64'(o_fcode[1]), 64'd0);

        // Clean straight-line retires.
        retire(32'h100);
        retire(32'h104);
        chk("clean_count32", 64'(o_cnt0), 64'd0);
        chk("clean_pulse32", 64'(o_pulse[0]), 64'd0);

        // Unflagged misaligned PC under IALIGN=32.
        retire(32'h102);
        chk("mis_flag32", 64'(o_mis[0]), 64'd1);
        chk("mis_pulse32", 64'(o_pulse[0]), 64'd1);
        chk("mis_code32", 64'(o_fcode[0]), 64'd1);
        chk("mis_pc32", 64'(o_fpc[0]), 64'h102);
        idle_cycle();
        chk("pulse_drop32", 64'(o_pulse[0]), 64'd0);

        // Two-hot decode, then the same vector waived by illegal.
        do_reset(1);
        retire(32'h300, 1'b0, 1'b0, '0, 1'b0, bad_dec);
        chk("onehot_flag32", 64'(o_oh[0]), 64'd1);
        chk("onehot_count32", 64'(o_cnt0), 64'd1);
        retire(32'h304, 1'b0, 1'b0, '0, 1'b0, bad_dec, 1'b1);
        chk("illegal_waive_pulse", 64'(o_pulse[0]), 64'd0);
        chk("illegal_waive_count", 64'(o_cnt0), 64'd1);

        // Compressed sequencing under IALIGN=16.
        do_reset(1);
        retire(32'h200, 1'b1);
        retire(32'h202);
        chk("c_seq_count16", 64'(o_cnt1), 64'd0);
        retire(32'h210);
        chk("pcseq_flag16", 64'(o_seq[1]), 64'd1);
        chk("pcseq_code16", 64'(o_fcode[1]), 64'd3);

        // Counter saturation at CNT_W=2, then clear racing a new error.
        do_reset(1);
        for (int i = 0; i < 5; i++) retire(32'h400 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b1, 37'd0);
        chk("sat_count16", 64'(o_cnt1), 64'd3);
        clear = 1'b1;
        retire(32'h500, 1'b0, 1'b0, '0, 1'b0, 37'd0);
        clear = 1'b0;
        chk("clr_err_count16", 64'(o_cnt1), 64'd1);
        chk("clr_err_code16", 64'(o_fcode[1]), 64'd2);
        chk("clr_err_mis16", 64'(o_mis[1]), 64'd0);

        // PC wrap is legal; reset mid-stream reseeds.
        do_reset(1);
        retire(32'hFFFF_FFFC);
        retire(32'h0);
        chk("wrap_seq32", 64'(o_seq[0]), 64'd0);
        chk("wrap_seq16", 64'(o_seq[1]), 64'd0);
        retire(32'h4);
        do_reset(1);
        retire(32'h500);
        chk("reseed_seq32", 64'(o_seq[0]), 64'd0);
        chk("reseed_count16", 64'(o_cnt1), 64'd0);

        // Randomized traffic against the model.
        seq_pc = 32'h1000;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, tgt;
            logic comp, redir, mis, ill, vld;
            logic [36:0] dec;
            cpu_rst = ($urandom_range(0, 99) < 2);
            clear   = ($urandom_range(0, 19) == 0);
            vld     = ($urandom_range(0, 3) != 0);
            pc      = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFE) : seq_pc;
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            comp    = ($urandom_range(0, 5) == 0);
            redir   = ($urandom_range(0, 4) == 0);
            tgt     = ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            mis     = (pc[1:0] != 2'b00) ^ ($urandom_range(0, 9) == 0);
            dec     = ($urandom_range(0, 7) == 0) ? 37'({$urandom(), $urandom()})
                                                  : (37'd1 << $urandom_range(0, 36));
            ill     = ($urandom_range(0, 9) == 0);
            ret_valid = vld; ret_pc = pc; ret_compressed = comp; ret_redirect = redir;
            ret_target = tgt; ret_misaligned = mis; ret_decode = dec; ret_illegal = ill;
            cycle();
            if (vld) seq_pc = redir ? tgt : pc + (comp ? 32'd2 : 32'd4);
        end
        cpu_rst = 1'b0; clear = 1'b0; ret_valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic idle_cycle();
        ret_valid = 1'b0;
        cycle();
    endtask

endmodule
